clk_ratio_detector: RTL and testbench
=====================================

// Module: clk_ratio_detector
// PURPOSE
//  Receive-side companion to the divided clocks generated in this design: samples a slow
//  clock/strobe (sig_in) in the clk_in domain and measures its period and high time in
//  clk_in cycles. Declares lock once the measured divide ratio is stable. Used to check
//  divider outputs and to recover the ratio of externally divided clocks.
// PARAMETERS
//  CNT_W       16  width of the cycle counter and of the period/high_time outputs
//  SYNC_STAGES 2   synchronizer flops on sig_in (>=2)
//  LOCK_COUNT  4   consecutive matching periods needed to assert locked (>=1)
//  TOL         0   max |period - previous period| still counted as a match, in cycles
//  TIMEOUT     60000 cycles since the last rise before timeout (< 2**CNT_W-1)
// PORTS
//  clk_in      in   1      only clock
//  rst_n       in   1      synchronous, active-low reset
//  sig_in      in   1      signal to measure; may be asynchronous to clk_in
//  period      out  CNT_W  last measured rise-to-rise period, in clk_in cycles
//  high_time   out  CNT_W  last measured rise-to-fall interval, in clk_in cycles
//  period_vld  out  1      1-cycle pulse when period is updated
//  locked      out  1      ratio stable; period holds the locked ratio
//  lock_lost   out  1      1-cycle pulse on the LOCKED->MEASURE transition
//  timeout     out  1      1-cycle pulse when no rise is seen for TIMEOUT cycles
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk_in edge): all outputs 0. Sync chain, counters and run
//    count cleared. FSM enters IDLE. Reset overrides everything, including mid-operation.
//  - s = last sync stage and s_d = s delayed one cycle. rise = s & ~s_d; fall = ~s & s_d.
//  - cnt (CNT_W): on rise cnt<=1, else cnt<=cnt+1, saturating at all-ones.
//    The value of cnt on a rise cycle is the period. The value on a fall cycle is high_time.
//  - fall, if at least one rise has been seen since IDLE: high_time<=cnt.
//  - FSM: IDLE, MEASURE, LOCKED.
//    IDLE: a rise moves to MEASURE and starts cnt. No period_vld.
//    MEASURE: each rise sets period<=cnt and pulses period_vld.
//      run: if run==0 or |cnt-prev|<=TOL, run<=run+1; else run<=1. prev<=cnt.
//      When run reaches LOCK_COUNT, move to LOCKED and set locked<=1 in the same update.
//    LOCKED: each rise pulses period_vld.
//      |cnt-period|<=TOL: stay LOCKED; period keeps the locked value.
//      Otherwise: period<=cnt, locked<=0, lock_lost pulse, run<=1, prev<=cnt, move to MEASURE.
//  - Timeout: in MEASURE/LOCKED, cnt==TIMEOUT && !rise -> timeout pulse, locked<=0, run<=0,
//    move to IDLE. No lock_lost pulse. period/high_time hold their last values.
//  - A rise in the timeout cycle wins: normal rise handling, no timeout.
//  - Differences are computed unsigned as max-min. No wrap-around.
//  - Latency: if sig_in is first sampled high at edge k, the internal rise is in the cycle
//    after edge k+SYNC_STAGES-1. period_vld/period/locked are visible after edge
//    k+SYNC_STAGES.
//  - Min measurable period is 2 (sig_in toggling every cycle). Max is TIMEOUT.
// TESTING
//  1. Reset, then sig_in = clk_in/6 (3 high, 3 low) -> period_vld on 2nd rise, period=6,
//     high_time=3; locked rises with the 5th rise's period_vld; lock_lost never pulses.
//  2. Locked at 6, switch to /10 -> first 10-cycle rise: period=10, locked=0, one
//     lock_lost pulse; relock on the 4th consecutive period of 10.
//  3. TIMEOUT=64, locked at 6, hold sig_in low -> timeout pulse exactly 64 cycles after
//     the last rise cycle; locked=0; the next rise gives no period_vld.
//  4. TOL=1, periods alternating 6/7 -> locks. Periods alternating 6/8 -> run stays 1 and
//     locked stays 0. TOL=0 with 6/7 -> no lock.
//  5. Locked at 6, rst_n low for 1 cycle -> all outputs 0 after that edge; lock needs
//     LOCK_COUNT fresh periods, first period_vld on the 2nd rise after reset.
//  6. sig_in toggling every clk_in cycle -> period=2, high_time=1, locks; a rise exactly
//     at cnt==TIMEOUT -> no timeout pulse.

Source files
------------

// File: rtl/clk_ratio_detector.sv
//------------------------------------------------------------------------------
// Module      : clk_ratio_detector
// Description : Measures a slow clock/strobe (sig_in) in the clk_in domain.
//               Reports its rise-to-rise period and rise-to-fall high time in
//               clk_in cycles, and declares lock once the period is stable.
// Ports       : clk_in     - only clock
//               rst_n      - synchronous active-low reset
//               sig_in     - signal to measure, may be asynchronous
//               period     - last measured period (locked ratio while locked)
//               high_time  - last measured high interval
//               period_vld - 1-cycle pulse on every measured rise
//               locked     - ratio stable
//               lock_lost  - 1-cycle pulse on leaving lock
//               timeout    - 1-cycle pulse when no rise for TIMEOUT cycles
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_ratio_detector #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0,
  parameter int TIMEOUT     = 60000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             locked,
  output logic             lock_lost,
  output logic             timeout
);

  localparam int                 c_run_w    = $clog2(LOCK_COUNT + 1);
  localparam logic [c_run_w-1:0] c_lock_run = c_run_w'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]   c_tol      = CNT_W'(TOL);
  localparam logic [CNT_W-1:0]   c_timeout  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_s_d;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_prev;
  logic [c_run_w-1:0]       r_run;
  logic                     r_seen;

  logic                     w_s;
  logic                     w_rise;
  logic                     w_fall;
  logic [CNT_W-1:0]         w_diff_prev;
  logic [CNT_W-1:0]         w_diff_per;
  logic                     w_match_prev;
  logic [c_run_w-1:0]       w_run_next;
  logic                     w_timeout_hit;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  // Unsigned distance max-min, so no wrap-around is possible.
  assign w_diff_prev = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
  assign w_diff_per  = (r_cnt >= period) ? (r_cnt - period) : (period - r_cnt);

  // A run of zero means no reference period yet, so the first one always counts.
  assign w_match_prev  = (r_run == '0) || (w_diff_prev <= c_tol);
  assign w_run_next    = w_match_prev ? (r_run + c_run_w'(1)) : c_run_w'(1);

  // A rise in the same cycle takes priority over the timeout.
  assign w_timeout_hit = (r_cnt == c_timeout) && !w_rise;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sync     <= '0;
      r_s_d      <= 1'b0;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_run      <= '0;
      r_seen     <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d      <= w_s;
      period_vld <= 1'b0;
      lock_lost  <= 1'b0;
      timeout    <= 1'b0;

      // Free-running interval counter, restarted at 1 by each rise.
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (!(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // High time is only meaningful once a rise has anchored the counter.
      if (w_fall && r_seen) begin
        high_time <= r_cnt;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_seen  <= 1'b1;
          end
        end

        ST_MEASURE: begin
          if (w_rise) begin
            period     <= r_cnt;
            period_vld <= 1'b1;
            r_run      <= w_run_next;
            r_prev     <= r_cnt;
            if (w_run_next == c_lock_run) begin
              r_state <= ST_LOCKED;
              locked  <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_run   <= '0;
            r_seen  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_LOCKED: begin
          if (w_rise) begin
            period_vld <= 1'b1;
            // Within tolerance the locked ratio is held rather than tracked.
            if (w_diff_per > c_tol) begin
              period    <= r_cnt;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              r_run     <= c_run_w'(1);
              r_prev    <= r_cnt;
              r_state   <= ST_MEASURE;
            end
          end else if (w_timeout_hit) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_run   <= '0;
            r_seen  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_ratio_detector.sv
//------------------------------------------------------------------------------
// Module      : tb_clk_ratio_detector
// Description : Self-checking bench for clk_ratio_detector. Two instances share
//               one stimulus: instance A with TOL=0, instance B with TOL=1,
//               both with TIMEOUT=64. A timestamp-based model predicts every
//               output on every cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_clk_ratio_detector;

  localparam int CNT_W = 16;
  localparam int S     = 2;
  localparam int LC    = 4;
  localparam int TO    = 64;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic sig_in = 1'b0;

  logic [CNT_W-1:0] per_a, hi_a, per_b, hi_b;
  logic vld_a, lk_a, ll_a, to_a;
  logic vld_b, lk_b, ll_b, to_b;

  always #5 clk_in = ~clk_in;

  clk_ratio_detector #(.CNT_W(CNT_W), .SYNC_STAGES(S), .LOCK_COUNT(LC), .TOL(0), .TIMEOUT(TO)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .period(per_a), .high_time(hi_a), .period_vld(vld_a),
    .locked(lk_a), .lock_lost(ll_a), .timeout(to_a)
  );

  clk_ratio_detector #(.CNT_W(CNT_W), .SYNC_STAGES(S), .LOCK_COUNT(LC), .TOL(1), .TIMEOUT(TO)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .period(per_b), .high_time(hi_b), .period_vld(vld_b),
    .locked(lk_b), .lock_lost(ll_b), .timeout(to_b)
  );

  // Model state: index 0 models dut_a, index 1 models dut_b.
  int  checks = 0;
  int  errors = 0;
  int  t      = 0;
  bit  h [0:S+1];
  int  m_mode   [2];   // 0 idle, 1 measuring, 2 locked
  int  m_tlast  [2];
  bit  m_seen   [2];
  int  m_runlen [2];
  int  m_runp   [2][8];
  int  m_period [2];
  int  m_high   [2];
  bit  m_vld    [2];
  bit  m_locked [2];
  bit  m_lost   [2];
  bit  m_to     [2];

  int  c_vld [2];
  int  c_lost[2];
  int  c_to  [2];
  int  vld_at_lock[2];
  int  t_last_vld [2];
  int  t_to       [2];
  bit  prev_lk    [2];

  function automatic int adiff(input int x, input int y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  // One model step for the edge just taken with inputs (x, r).
  task automatic step_model(input bit x, input bit r);
    bit s, sd, rise, fall;
    int el, tol;
    if (!r) begin
      for (int j = 0; j <= S + 1; j++) h[j] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_seen[i] = 0; m_runlen[i] = 0; m_tlast[i] = t;
        m_period[i] = 0; m_high[i] = 0;
        m_vld[i] = 0; m_locked[i] = 0; m_lost[i] = 0; m_to[i] = 0;
      end
      return;
    end
    for (int j = S + 1; j >= 1; j--) h[j] = h[j-1];
    h[0] = x;
    // The rise acted on at this edge is the sample taken S edges ago.
    s    = h[S];
    sd   = h[S+1];
    rise = s & !sd;
    fall = !s & sd;
    for (int i = 0; i < 2; i++) begin
      tol = i;
      el  = t - m_tlast[i];
      m_vld[i] = 0; m_lost[i] = 0; m_to[i] = 0;
      if (fall && m_seen[i]) m_high[i] = el;
      if (rise) begin
        if (m_mode[i] == 1) begin
          m_period[i] = el;
          m_vld[i]    = 1;
          if (m_runlen[i] == 0 || adiff(el, m_runp[i][m_runlen[i]-1]) <= tol) begin
            m_runp[i][m_runlen[i]] = el;
            m_runlen[i]++;
          end else begin
            m_runp[i][0] = el;
            m_runlen[i]  = 1;
          end
          if (m_runlen[i] == LC) begin
            m_mode[i]   = 2;
            m_locked[i] = 1;
          end
        end else if (m_mode[i] == 2) begin
          m_vld[i] = 1;
          if (adiff(el, m_period[i]) > tol) begin
            m_period[i]  = el;
            m_locked[i]  = 0;
            m_lost[i]    = 1;
            m_runp[i][0] = el;
            m_runlen[i]  = 1;
            m_mode[i]    = 1;
          end
        end else begin
          m_mode[i] = 1;
        end
        m_tlast[i] = t;
        m_seen[i]  = 1;
      end else if (m_mode[i] != 0 && el == TO) begin
        m_to[i]     = 1;
        m_locked[i] = 0;
        m_runlen[i] = 0;
        m_seen[i]   = 0;
        m_mode[i]   = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_period",    32'(per_a), 32'(m_period[0]));
    chk("a_high_time", 32'(hi_a),  32'(m_high[0]));
    chk("a_period_vld",32'(vld_a), 32'(m_vld[0]));
    chk("a_locked",    32'(lk_a),  32'(m_locked[0]));
    chk("a_lock_lost", 32'(ll_a),  32'(m_lost[0]));
    chk("a_timeout",   32'(to_a),  32'(m_to[0]));
    chk("b_period",    32'(per_b), 32'(m_period[1]));
    chk("b_high_time", 32'(hi_b),  32'(m_high[1]));
    chk("b_period_vld",32'(vld_b), 32'(m_vld[1]));
    chk("b_locked",    32'(lk_b),  32'(m_locked[1]));
    chk("b_lock_lost", 32'(ll_b),  32'(m_lost[1]));
    chk("b_timeout",   32'(to_b),  32'(m_to[1]));
  endtask

  task automatic cyc(input logic s_v, input logic r_v);
    sig_in = s_v;
    rst_n  = r_v;
    @(posedge clk_in);
    t++;
    step_model(s_v, r_v);
    #1;
    compare_all();
    for (int i = 0; i < 2; i++) begin
      if (m_vld[i])  begin c_vld[i]++; t_last_vld[i] = t; end
      if (m_lost[i]) c_lost[i]++;
      if (m_to[i])   begin c_to[i]++; t_to[i] = t; end
      if (m_locked[i] && !prev_lk[i]) vld_at_lock[i] = c_vld[i];
      prev_lk[i] = m_locked[i];
    end
  endtask

  task automatic div(input int hi, input int lo);
    repeat (hi) cyc(1'b1, 1'b1);
    repeat (lo) cyc(1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      c_vld[i] = 0; c_lost[i] = 0; c_to[i] = 0; vld_at_lock[i] = -1;
      prev_lk[i] = m_locked[i];
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0);
    clear_counts();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) t_last_vld[i] = 0;
    // Reset state
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_period", 32'(per_a), 32'd0);
    chk("rst_locked", 32'(lk_b), 32'd0);

    // 1: divide by 6, 3 high / 3 low
    do_reset();
    repeat (8) div(3, 3);
    chk("t1_vld_at_lock", 32'(vld_at_lock[0]), 32'd4);
    chk("t1_vld_count",   32'(c_vld[0]),       32'd7);
    chk("t1_period",      32'(m_period[0]),    32'd6);
    chk("t1_high",        32'(m_high[0]),      32'd3);
    chk("t1_locked",      32'(m_locked[0]),    32'd1);
    chk("t1_lost",        32'(c_lost[0]),      32'd0);

    // 2: switch from /6 to /10
    clear_counts();
    repeat (6) div(5, 5);
    chk("t2_lost_a",       32'(c_lost[0]),      32'd1);
    chk("t2_lost_b",       32'(c_lost[1]),      32'd1);
    chk("t2_vld_at_relock",32'(vld_at_lock[0]), 32'd5);
    chk("t2_period",       32'(m_period[0]),    32'd10);
    chk("t2_high",         32'(m_high[0]),      32'd5);
    chk("t2_locked",       32'(m_locked[0]),    32'd1);

    // 3: locked at 6 then sig_in held low
    do_reset();
    repeat (6) div(3, 3);
    clear_counts();
    repeat (80) cyc(1'b0, 1'b1);
    chk("t3_timeouts",   32'(c_to[0]),                  32'd1);
    chk("t3_to_latency", 32'(t_to[0] - t_last_vld[0]),  32'd64);
    chk("t3_locked",     32'(m_locked[0]),              32'd0);
    chk("t3_no_lost",    32'(c_lost[0]),                32'd0);
    div(3, 3);
    chk("t3_first_rise_novld", 32'(c_vld[0]), 32'd0);
    div(3, 3);
    chk("t3_second_rise_vld",  32'(c_vld[0]), 32'd1);
    chk("t3_period_after",     32'(m_period[0]), 32'd6);

    // 4: tolerance, alternating 6/7 then 6/8
    do_reset();
    repeat (6) begin div(3, 3); div(3, 4); end
    chk("t4_tol1_locked", 32'(m_locked[1]), 32'd1);
    chk("t4_tol0_nolock", 32'(m_locked[0]), 32'd0);
    do_reset();
    repeat (6) begin div(3, 3); div(3, 5); end
    chk("t4_68_tol1_nolock", 32'(m_locked[1]), 32'd0);
    chk("t4_68_tol0_nolock", 32'(m_locked[0]), 32'd0);
    chk("t4_68_vld",         32'(c_vld[1]),    32'd11);

    // 5: reset while locked
    do_reset();
    repeat (6) div(3, 3);
    chk("t5_pre_locked", 32'(m_locked[0]), 32'd1);
    do_reset();
    chk("t5_rst_period", 32'(m_period[0]), 32'd0);
    chk("t5_rst_locked", 32'(m_locked[0]), 32'd0);
    repeat (5) div(3, 3);
    chk("t5_vld_at_lock", 32'(vld_at_lock[0]), 32'd4);
    chk("t5_locked",      32'(m_locked[0]),    32'd1);

    // 6: toggle every cycle, then a rise exactly at cnt==TIMEOUT
    do_reset();
    repeat (10) div(1, 1);
    chk("t6_period", 32'(m_period[0]), 32'd2);
    chk("t6_high",   32'(m_high[0]),   32'd1);
    chk("t6_locked", 32'(m_locked[0]), 32'd1);
    clear_counts();
    repeat (62) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1);
    chk("t6_no_timeout", 32'(c_to[0]),     32'd0);
    chk("t6_period_64",  32'(m_period[0]), 32'd64);
    chk("t6_lost",       32'(c_lost[0]),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
